// File: rtl/timer_pkg.sv
// Shared definitions for the programmable down-counting timer:
// register address map and CTRL/STATUS bit positions.
package timer_pkg;

  typedef enum logic [2:0] {
    REG_COUNT_LO  = 3'd0,
    REG_COUNT_HI  = 3'd1,
    REG_RELOAD_LO = 3'd2,
    REG_RELOAD_HI = 3'd3,
    REG_PRESCALE  = 3'd4,
    REG_CTRL      = 3'd5,
    REG_STATUS    = 3'd6,
    REG_RSVD      = 3'd7
  } reg_addr_e;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IEN      = 2;
  localparam int CTRL_W        = 3;

  localparam int STATUS_EXP    = 0;

endpackage

// File: rtl/timer_prescaler.sv
// Programmable clock divider: issues a one-cycle tick every div+1 enabled clocks.
// The counter freezes while en is low and restarts from zero on clr.
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;

  assign tick = en & (cnt_r == div);

  // Next prescaler value: clear dominates, wrap on tick, advance only while enabled
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = 8'd0;
    end else if (tick) begin
      cnt_nxt_s = 8'd0;
    end else if (en) begin
      cnt_nxt_s = cnt_r + 8'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Prescaler state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/timer_irq.sv
// 16-bit down-counting timer with prescaler, one-shot/periodic modes,
// coherent two-byte count readback and an active-low level interrupt.
module timer_irq
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rwb,
  input  logic [2:0] addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       irqb
);

  reg_addr_e          reg_sel_s;
  logic               wr_s;
  logic               rd_s;
  logic               wr_reload_hi_s;
  logic               wr_ctrl_s;
  logic               wr_status_s;
  logic               en_rise_s;
  logic               presc_clr_s;
  logic               tick_s;
  logic               expire_s;

  logic [15:0]        count_r;
  logic [15:0]        count_nxt_s;
  logic [7:0]         shadow_r;
  logic [7:0]         reload_lo_r;
  logic [7:0]         reload_hi_r;
  logic [7:0]         prescale_r;
  logic [CTRL_W-1:0]  ctrl_r;
  logic [CTRL_W-1:0]  ctrl_nxt_s;
  logic               exp_r;
  logic               exp_nxt_s;

  assign reg_sel_s      = reg_addr_e'(addr);
  assign wr_s           = cs & ~rwb;
  assign rd_s           = cs & rwb;
  assign wr_reload_hi_s = wr_s & (reg_sel_s == REG_RELOAD_HI);
  assign wr_ctrl_s      = wr_s & (reg_sel_s == REG_CTRL);
  assign wr_status_s    = wr_s & (reg_sel_s == REG_STATUS);
  assign en_rise_s      = wr_ctrl_s & i_data[CTRL_EN] & ~ctrl_r[CTRL_EN];
  assign presc_clr_s    = wr_reload_hi_s | en_rise_s;
  // A reload write consumes a coincident tick entirely, so it cannot expire either
  assign expire_s       = tick_s & (count_r == 16'd0) & ~wr_reload_hi_s;
  assign irqb           = ~(exp_r & ctrl_r[CTRL_IEN]);

  timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_r[CTRL_EN]),
    .clr   (presc_clr_s),
    .div   (prescale_r),
    .tick  (tick_s)
  );

  // Next count: software reload beats tick; a zero count reloads or holds on tick
  always_comb begin
    count_nxt_s = count_r;
    if (wr_reload_hi_s) begin
      count_nxt_s = {i_data, reload_lo_r};
    end else if (tick_s) begin
      if (count_r != 16'd0) begin
        count_nxt_s = count_r - 16'd1;
      end else if (ctrl_r[CTRL_PERIODIC]) begin
        count_nxt_s = {reload_hi_r, reload_lo_r};
      end else begin
        count_nxt_s = count_r;
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Next CTRL and EXP: software CTRL writes win, expiry sets EXP over a clear
  always_comb begin
    ctrl_nxt_s = ctrl_r;
    exp_nxt_s  = exp_r;
    if (wr_ctrl_s) begin
      ctrl_nxt_s = i_data[CTRL_W-1:0];
    end else if (expire_s && !ctrl_r[CTRL_PERIODIC]) begin
      ctrl_nxt_s[CTRL_EN] = 1'b0;
    end else begin
      ctrl_nxt_s = ctrl_r;
    end
    if (expire_s) begin
      exp_nxt_s = 1'b1;
    end else if (wr_status_s && i_data[STATUS_EXP]) begin
      exp_nxt_s = 1'b0;
    end else begin
      exp_nxt_s = exp_r;
    end
  end

  // Architectural register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r     <= 16'd0;
      shadow_r    <= 8'd0;
      reload_lo_r <= 8'd0;
      reload_hi_r <= 8'd0;
      prescale_r  <= 8'd0;
      ctrl_r      <= {CTRL_W{1'b0}};
      exp_r       <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      ctrl_r  <= ctrl_nxt_s;
      exp_r   <= exp_nxt_s;
      if (rd_s && (reg_sel_s == REG_COUNT_LO)) begin
        shadow_r <= count_r[15:8];
      end else begin
        shadow_r <= shadow_r;
      end
      if (wr_s && (reg_sel_s == REG_RELOAD_LO)) begin
        reload_lo_r <= i_data;
      end else begin
        reload_lo_r <= reload_lo_r;
      end
      if (wr_reload_hi_s) begin
        reload_hi_r <= i_data;
      end else begin
        reload_hi_r <= reload_hi_r;
      end
      if (wr_s && (reg_sel_s == REG_PRESCALE)) begin
        prescale_r <= i_data;
      end else begin
        prescale_r <= prescale_r;
      end
    end
  end

  // Read mux; COUNT_HI returns the byte captured by the last COUNT_LO read
  always_comb begin
    o_data = 8'h00;
    if (rd_s) begin
      case (reg_sel_s)
        REG_COUNT_LO:  o_data = count_r[7:0];
        REG_COUNT_HI:  o_data = shadow_r;
        REG_RELOAD_LO: o_data = reload_lo_r;
        REG_RELOAD_HI: o_data = reload_hi_r;
        REG_PRESCALE:  o_data = prescale_r;
        REG_CTRL:      o_data = {5'd0, ctrl_r};
        REG_STATUS:    o_data = {7'd0, exp_r};
        default:       o_data = 8'h00;
      endcase
    end else begin
      o_data = 8'h00;
    end
  end

endmodule

// File: tb/tb_timer_irq.sv
// Directed self-checking bench for timer_irq: register access, one-shot and
// periodic expiry, coherent count reads, same-edge races and reset abort.
module tb_timer_irq;
  import timer_pkg::*;

  logic       clk;
  logic       reset;
  logic       cs;
  logic       rwb;
  logic [2:0] addr;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic       irqb;

  int tests;
  int fails;

  timer_irq dut (
    .clk    (clk),
    .reset  (reset),
    .cs     (cs),
    .rwb    (rwb),
    .addr   (addr),
    .i_data (i_data),
    .o_data (o_data),
    .irqb   (irqb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entered and left at a negedge; the write lands on the posedge in between.
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; rwb = 1'b0; addr = a; i_data = d;
    @(negedge clk);
    cs = 1'b0; rwb = 1'b1;
  endtask

  // Samples o_data before the posedge, which also latches the shadow byte.
  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b1; rwb = 1'b1; addr = a;
    #1 d = o_data;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cs = 1'b1; rwb = 1'b1; addr = 3'd6; i_data = 8'h00;
    repeat (2) @(negedge clk);
    tests++; if (irqb !== 1'b1) begin $display("FAIL reset_irqb got %b want 1", irqb); fails++; end
    tests++; if (o_data !== 8'h00) begin $display("FAIL reset_odata got %h want 00", o_data); fails++; end
    reset = 1'b1; cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_oneshot();
    logic [7:0] d;
    wr(REG_PRESCALE, 8'h00); wr(REG_RELOAD_LO, 8'h03); wr(REG_RELOAD_HI, 8'h00);
    wr(REG_CTRL, 8'h05);
    repeat (3) @(negedge clk);
    tests++; if (irqb !== 1'b1) begin $display("FAIL oneshot_early got %b want 1", irqb); fails++; end
    @(negedge clk);
    tests++; if (irqb !== 1'b0) begin $display("FAIL oneshot_irq got %b want 0", irqb); fails++; end
    rd(REG_STATUS, d);
    tests++; if (d !== 8'h01) begin $display("FAIL oneshot_status got %h want 01", d); fails++; end
    rd(REG_CTRL, d);
    tests++; if (d !== 8'h04) begin $display("FAIL oneshot_ctrl got %h want 04", d); fails++; end
    repeat (3) @(negedge clk);
    rd(REG_COUNT_LO, d);
    tests++; if (d !== 8'h00) begin $display("FAIL oneshot_hold got %h want 00", d); fails++; end
    wr(REG_STATUS, 8'h01);
    tests++; if (irqb !== 1'b1) begin $display("FAIL oneshot_clear got %b want 1", irqb); fails++; end
  endtask

  task automatic test_periodic_and_race();
    logic [7:0] d;
    wr(REG_PRESCALE, 8'h03); wr(REG_RELOAD_LO, 8'h01); wr(REG_RELOAD_HI, 8'h00);
    wr(REG_CTRL, 8'h07);
    repeat (7) @(negedge clk);
    tests++; if (irqb !== 1'b1) begin $display("FAIL periodic_pre1 got %b want 1", irqb); fails++; end
    @(negedge clk);
    tests++; if (irqb !== 1'b0) begin $display("FAIL periodic_exp1 got %b want 0", irqb); fails++; end
    wr(REG_STATUS, 8'h01);
    tests++; if (irqb !== 1'b1) begin $display("FAIL periodic_clr got %b want 1", irqb); fails++; end
    repeat (6) @(negedge clk);
    tests++; if (irqb !== 1'b1) begin $display("FAIL periodic_pre2 got %b want 1", irqb); fails++; end
    @(negedge clk);
    tests++; if (irqb !== 1'b0) begin $display("FAIL periodic_exp2 got %b want 0", irqb); fails++; end
    // Third expiry lands on the same edge as this clear
    repeat (7) @(negedge clk);
    wr(REG_STATUS, 8'h01);
    tests++; if (irqb !== 1'b0) begin $display("FAIL race_irqb got %b want 0", irqb); fails++; end
    rd(REG_STATUS, d);
    tests++; if (d !== 8'h01) begin $display("FAIL race_status got %h want 01", d); fails++; end
    wr(REG_STATUS, 8'h01);
    tests++; if (irqb !== 1'b1) begin $display("FAIL race_clear got %b want 1", irqb); fails++; end
    wr(REG_CTRL, 8'h00);
  endtask

  task automatic test_coherent_read();
    logic [7:0] d;
    wr(REG_PRESCALE, 8'h00); wr(REG_RELOAD_LO, 8'hFF); wr(REG_RELOAD_HI, 8'h12);
    rd(REG_COUNT_LO, d);
    tests++; if (d !== 8'hFF) begin $display("FAIL coh1_lo got %h want ff", d); fails++; end
    wr(REG_CTRL, 8'h01); wr(REG_CTRL, 8'h00);
    rd(REG_COUNT_HI, d);
    tests++; if (d !== 8'h12) begin $display("FAIL coh1_hi got %h want 12", d); fails++; end
    rd(REG_COUNT_LO, d);
    tests++; if (d !== 8'hFE) begin $display("FAIL coh1_dec got %h want fe", d); fails++; end
    wr(REG_RELOAD_LO, 8'h00); wr(REG_RELOAD_HI, 8'h13);
    rd(REG_COUNT_LO, d);
    tests++; if (d !== 8'h00) begin $display("FAIL coh2_lo got %h want 00", d); fails++; end
    wr(REG_CTRL, 8'h01); wr(REG_CTRL, 8'h00);
    rd(REG_COUNT_HI, d);
    tests++; if (d !== 8'h13) begin $display("FAIL coh2_hi got %h want 13", d); fails++; end
    rd(REG_COUNT_LO, d);
    tests++; if (d !== 8'hFF) begin $display("FAIL coh2_lo2 got %h want ff", d); fails++; end
    rd(REG_COUNT_HI, d);
    tests++; if (d !== 8'h12) begin $display("FAIL coh2_hi2 got %h want 12", d); fails++; end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    wr(REG_RELOAD_LO, 8'h10); wr(REG_RELOAD_HI, 8'h00);
    wr(REG_CTRL, 8'h01);
    wr(REG_RELOAD_HI, 8'h00);
    rd(REG_COUNT_LO, d);
    tests++; if (d !== 8'h10) begin $display("FAIL b2b_write_wins got %h want 10", d); fails++; end
    wr(REG_CTRL, 8'h00);
    rd(REG_COUNT_LO, d);
    tests++; if (d !== 8'h0E) begin $display("FAIL b2b_after got %h want 0e", d); fails++; end
  endtask

  task automatic test_zero_start();
    logic [7:0] d;
    wr(REG_PRESCALE, 8'h02); wr(REG_RELOAD_LO, 8'h00); wr(REG_RELOAD_HI, 8'h00);
    wr(REG_COUNT_LO, 8'h55); wr(REG_COUNT_HI, 8'h66); wr(REG_RSVD, 8'hFF);
    rd(REG_COUNT_LO, d);
    tests++; if (d !== 8'h00) begin $display("FAIL cnt_wr_ignored got %h want 00", d); fails++; end
    rd(REG_RSVD, d);
    tests++; if (d !== 8'h00) begin $display("FAIL rsvd got %h want 00", d); fails++; end
    wr(REG_CTRL, 8'h05);
    repeat (2) @(negedge clk);
    tests++; if (irqb !== 1'b1) begin $display("FAIL zero_early got %b want 1", irqb); fails++; end
    @(negedge clk);
    tests++; if (irqb !== 1'b0) begin $display("FAIL zero_first_tick got %b want 0", irqb); fails++; end
    rd(REG_CTRL, d);
    tests++; if (d !== 8'h04) begin $display("FAIL zero_ctrl got %h want 04", d); fails++; end
    rd(REG_PRESCALE, d);
    tests++; if (d !== 8'h02) begin $display("FAIL prescale_rb got %h want 02", d); fails++; end
    wr(REG_STATUS, 8'h01);
  endtask

  task automatic test_ien_gate();
    logic [7:0] d;
    wr(REG_PRESCALE, 8'h00); wr(REG_RELOAD_LO, 8'h02); wr(REG_RELOAD_HI, 8'h00);
    wr(REG_CTRL, 8'h03);
    repeat (3) @(negedge clk);
    tests++; if (irqb !== 1'b1) begin $display("FAIL ien_masked got %b want 1", irqb); fails++; end
    rd(REG_STATUS, d);
    tests++; if (d !== 8'h01) begin $display("FAIL ien_status got %h want 01", d); fails++; end
    wr(REG_STATUS, 8'h00);
    wr(REG_CTRL, 8'h07);
    tests++; if (irqb !== 1'b0) begin $display("FAIL ien_enable got %b want 0", irqb); fails++; end
    wr(REG_CTRL, 8'h03);
    tests++; if (irqb !== 1'b1) begin $display("FAIL ien_disable got %b want 1", irqb); fails++; end
    wr(REG_CTRL, 8'h07);
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    wr(REG_RELOAD_LO, 8'h00); wr(REG_RELOAD_HI, 8'h01);
    tests++; if (irqb !== 1'b0) begin $display("FAIL mid_pre_irq got %b want 0", irqb); fails++; end
    reset = 1'b0; cs = 1'b1; rwb = 1'b1; addr = REG_STATUS;
    #1;
    tests++; if (irqb !== 1'b1) begin $display("FAIL mid_irqb got %b want 1", irqb); fails++; end
    tests++; if (o_data !== 8'h00) begin $display("FAIL mid_odata got %h want 00", o_data); fails++; end
    @(negedge clk);
    reset = 1'b1; cs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), d);
      tests++; if (d !== 8'h00) begin $display("FAIL mid_reg%0d got %h want 00", i, d); fails++; end
    end
    repeat (20) @(negedge clk);
    rd(REG_COUNT_LO, d);
    tests++; if (d !== 8'h00) begin $display("FAIL mid_no_tick got %h want 00", d); fails++; end
    rd(REG_STATUS, d);
    tests++; if (d !== 8'h00) begin $display("FAIL mid_no_exp got %h want 00", d); fails++; end
    tests++; if (irqb !== 1'b1) begin $display("FAIL mid_irqb_after got %b want 1", irqb); fails++; end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_oneshot();
    test_periodic_and_race();
    test_coherent_read();
    test_back_to_back();
    test_zero_start();
    test_ien_gate();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timer_irq.md
TIMER_IRQ -- requirements
Module: timer_irq

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; clears all state when low.
REQ-003 cs  input  1  chip select from address decode, active-high.
REQ-004 rwb  input  1  bus direction: 1 = read, 0 = write.
REQ-005 addr  input  3  register select.
REQ-006 i_data  input  8  write data from CPU.
REQ-007 o_data  output  8  read data to CPU.
REQ-008 irqb  output  1  active-low level interrupt; drives one irqb input of the interrupt controller.

Function
REQ-009 Register map by addr:
- 0 COUNT_LO
- 1 COUNT_HI
- 2 RELOAD_LO
- 3 RELOAD_HI
- 4 PRESCALE
- 5 CTRL: bit0 EN, bit1 PERIODIC, bit2 IEN, bits 7:3 read as 0
- 6 STATUS: bit0 EXP, bits 7:1 read as 0
- 7 reserved: reads 0x00, writes ignored.
REQ-010 Write: cs & ~rwb sampled on a clk edge writes i_data to the addressed register at that edge.
REQ-011 Read: o_data is combinational from addr when cs & rwb; it is 0x00 otherwise.
REQ-012 Coherent count read:
- A read of COUNT_LO returns the live count[7:0].
- The same edge latches count[15:8] into a shadow byte.
- A COUNT_HI read returns the shadow byte, never the live byte.
REQ-013 Writing RELOAD_HI loads count <= {i_data, RELOAD_LO} and clears the prescaler at the same edge; writing RELOAD_LO alone does not affect count.
REQ-014 Writes to COUNT_LO/COUNT_HI are ignored.
REQ-015 Prescaler:
- An 8-bit counter runs while EN=1.
- A tick is issued on the cycle where prescaler == PRESCALE; the prescaler returns to 0 on that cycle.
- Ticks therefore occur every PRESCALE+1 clocks.
- PRESCALE=0 gives a tick every clock.
REQ-016 On a tick with count != 0, count decrements by 1.
REQ-017 On a tick with count == 0:
- EXP is set.
- If PERIODIC=1, count reloads from {RELOAD_HI, RELOAD_LO}.
- If PERIODIC=0, count holds at 0 and EN clears.
REQ-018 A CTRL write that changes EN from 0 to 1 clears the prescaler; EN=0 freezes both count and prescaler.
REQ-019 A STATUS write with i_data[0]=1 clears EXP; a write with i_data[0]=0 has no effect.
REQ-020 If a clear of EXP and an expiry occur on the same edge, EXP ends set (set wins).
REQ-021 If a RELOAD_HI write and a tick occur on the same edge, the write wins: count takes the new reload value and no decrement occurs.
REQ-022 irqb = ~(EXP & IEN), decoded combinationally from registered state, glitch-free.
- irqb falls in the cycle after the expiring edge.
- irqb rises in the cycle after the clearing write, or after IEN is cleared.
REQ-023 A CTRL write with EN=1 and count=0 expires on the first tick.

Reset
REQ-024 While reset=0, the following are all zero: count, shadow, RELOAD, PRESCALE, prescaler, CTRL, EXP.
REQ-025 While reset=0, irqb=1 and o_data=0x00.
REQ-026 Reset asserted mid-count aborts the count with no interrupt; operation resumes only after software reprogramming.

Structure
REQ-027 Package timer_pkg holds:
- the register address enum (REG_COUNT_LO .. REG_RSVD);
- CTRL bit-position constants CTRL_EN, CTRL_PERIODIC, CTRL_IEN;
- the STATUS_EXP constant.
REQ-028 The prescaler shall be the sub-module timer_prescaler, with ports:
- clk, reset, en, clr, div[7:0] (inputs);
- tick (output).

Verification
REQ-029 PRESCALE=0, RELOAD=0x0003, CTRL=0x05 (one-shot, IEN):
- ticks every clock; EXP set 4 clocks after the enabling edge;
- irqb low the next cycle; EN reads 0; count holds at 0.
REQ-030 PRESCALE=3, RELOAD=0x0001, CTRL=0x07 (periodic):
- EXP first sets after 8 clocks;
- clear EXP by writing STATUS=0x01, then EXP sets again 8 clocks later;
- irqb toggles accordingly.
REQ-031 Count=0x12FF, read COUNT_LO, then let the decrement to 0x12FE carry on, then read COUNT_HI:
- reads return 0xFF and then 0x12.
- Repeat with count=0x1300 crossing to 0x12FF: reads return 0x00 and then 0x13.
REQ-032 STATUS clear (write 0x01) on the same edge as an expiry:
- EXP reads 1; irqb stays low.
REQ-033 CTRL=0x03 (IEN=0), run to expiry:
- EXP=1 and irqb stays high;
- then write CTRL=0x07: irqb falls the next cycle.
REQ-034 Assert reset mid-count with EXP=1:
- irqb=1, all registers read 0x00, and no tick occurs after release.
